byte_encode_ctrl: RTL

Streaming controller that sequences the ML-KEM ByteEncode_d bit-packing datapath. It accepts N_COEFFS coefficients of d bits each over a valid/ready input stream and packs them little-endian into a bit accumulator. It emits bytes over a valid/ready output stream. It sits between the compress stage and the byte-oriented output buffer and replaces the flat, all-at-once bits-to-bytes conversion with a buffered, backpressure-aware sequence.

---
 rtl/byte_encode_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/byte_encode_ctrl.sv
// ByteEncode_d packing controller: accepts d-bit coefficients, packs them
// little-endian into a small bit accumulator and streams out bytes with backpressure.
module byte_encode_ctrl #(
  parameter int N_COEFFS = 256,
  parameter int D_MAX    = 12,
  parameter int COEFF_W  = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         d_i,
  input  logic [COEFF_W-1:0] coeff_i,
  input  logic               coeff_valid_i,
  output logic               coeff_ready_o,
  output logic [7:0]         byte_o,
  output logic               byte_valid_o,
  input  logic               byte_ready_i,
  output logic               byte_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int ACC_W     = D_MAX + 7;
  localparam int MAX_BYTES = N_COEFFS * D_MAX / 8;
  localparam int CC_W      = $clog2(N_COEFFS + 1);
  localparam int BC_W      = $clog2(MAX_BYTES + 1);
  localparam int BIT_W     = $clog2(ACC_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ACC_W-1:0]  acc_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [CC_W-1:0]   coeff_cnt_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [3:0]        d_q;
  logic              start_ok;
  logic              accept;
  logic              pop;

  // Keep only the low d bits of a coefficient, widened to the accumulator.
  function automatic logic [ACC_W-1:0] mask_coeff(input logic [COEFF_W-1:0] c,
                                                  input logic [3:0] d);
    logic [ACC_W-1:0] mask;
    mask = (ACC_W'(1) << d) - ACC_W'(1);
    return ACC_W'(c) & mask;
  endfunction

  // Index of the final byte of an operation: N_COEFFS*d/8 - 1.
  function automatic logic [BC_W-1:0] final_byte_idx(input logic [3:0] d);
    logic [31:0] nbytes;
    nbytes = (32'(N_COEFFS) * 32'(d)) >> 3;
    return BC_W'(nbytes - 32'd1);
  endfunction

  function automatic logic d_legal(input logic [3:0] d);
    return (d != 4'd0) && (32'(d) <= 32'(D_MAX));
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    start_ok      = 1'b0;
    coeff_ready_o = 1'b0;
    byte_valid_o  = 1'b0;
    byte_last_o   = 1'b0;
    busy_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (d_legal(d_i)) begin
            start_ok = 1'b1;
            state_d  = PACK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PACK: begin
        busy_o        = 1'b1;
        // Ready and valid split on bit_cnt, so accept and pop never coincide.
        coeff_ready_o = (coeff_cnt_q < CC_W'(N_COEFFS)) && (bit_cnt_q < BIT_W'(8));
        byte_valid_o  = (bit_cnt_q >= BIT_W'(8));
        byte_last_o   = byte_valid_o && (byte_cnt_q == final_byte_idx(d_q));
        if (byte_valid_o && byte_ready_i && byte_last_o) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = coeff_ready_o && coeff_valid_i;
  assign pop    = byte_valid_o && byte_ready_i;
  assign byte_o = acc_q[7:0];
  assign done_o = done_q;
  assign err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      coeff_cnt_q <= '0;
      byte_cnt_q  <= '0;
      d_q         <= '0;
    end else if (start_ok) begin
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      coeff_cnt_q <= '0;
      byte_cnt_q  <= '0;
      d_q         <= d_i;
    end else if (accept) begin
      acc_q       <= acc_q | (mask_coeff(coeff_i, d_q) << bit_cnt_q);
      bit_cnt_q   <= bit_cnt_q + BIT_W'(d_q);
      coeff_cnt_q <= coeff_cnt_q + CC_W'(1);
    end else if (pop) begin
      acc_q       <= acc_q >> 8;
      bit_cnt_q   <= bit_cnt_q - BIT_W'(8);
      byte_cnt_q  <= byte_cnt_q + BC_W'(1);
    end
  end

endmodule
